// File: rtl/icache_arb_pkg.sv
// Shared types and constants for the i-cache memory arbiter.
package icache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int LINE_BEATS = 16;
  localparam int LINE_BYTES = 16;

  // Beat index on which the memory is expected to release its busywait.
  localparam logic [3:0] LAST_BEAT = 4'(LINE_BEATS - 1);

endpackage

// File: rtl/icache_arb_pick.sv
// Combinational winner select; round-robin from ptr when ICACHE_ARB_RR_EN is
// defined, otherwise fixed priority with index 0 highest.
module icache_arb_pick
  import icache_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  logic [NUM_REQ-1:0] cand;

`ifdef ICACHE_ARB_RR_EN
  // Requests at or above the pointer take precedence; wrap to the full vector otherwise.
  logic [NUM_REQ-1:0] upper;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_upper
      assign upper[gi] = req[gi] && (gi >= int'(ptr));
    end
  endgenerate

  assign cand = (|upper) ? upper : req;
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign cand       = req;
`endif

  assign valid = |req;

  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) winner = ID_W'(i);
    end
  end

endmodule

// File: rtl/icache_mem_arbiter.sv
// Shares one byte-serial instruction memory among NUM_REQ i-caches, one 16-beat
// line fill at a time. Define ICACHE_ARB_RR_EN for round-robin arbitration.
module icache_mem_arbiter
  import icache_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  output logic [LINE_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_busywait,
  output logic                        mem_read,
  output logic [ADDR_W-1:0]           mem_address,
  input  logic [LINE_W-1:0]           mem_readdata,
  input  logic                        mem_busywait,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        sync_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        beat;
  logic              any_req;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   ptr;
  logic              grant;
  logic [ADDR_W-1:0] slot_addr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign slot_addr[gi]    = req_address[gi*ADDR_W +: ADDR_W];
      assign req_busywait[gi] = req_read[gi] && !(state == DONE && int'(grant_id) == gi);
    end
  endgenerate

  icache_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req_read),
    .ptr    (ptr),
    .valid  (any_req),
    .winner (winner)
  );

  assign grant = (state == IDLE) && any_req;

`ifdef ICACHE_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;

  // Next search starts just past the cache that was granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (!mem_busywait) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read = (state == BUSY);
  end

  // The beat counter is never cleared on a new fill: it mirrors the memory's own
  // counter, which only restarts on the shared reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_id <= '0;
      addr     <= '0;
      beat     <= '0;
      sync_err <= 1'b0;
    end else begin
      if (grant) begin
        grant_id <= winner;
        addr     <= slot_addr[winner];
      end
      if (state == BUSY) begin
        beat <= beat + 4'd1;
        if ((!mem_busywait && beat != LAST_BEAT) || (mem_busywait && beat == LAST_BEAT))
          sync_err <= 1'b1;
      end
    end
  end

  assign mem_address  = addr;
  assign req_readdata = mem_readdata;

endmodule

// File: doc/icache_mem_arbiter.md
# icache_mem_arbiter

Arbitrates a single byte-serial instruction memory among NUM_REQ instruction caches, the per-context caches selected by OS-initiated cache switching. It latches the winning cache's line address and holds the memory read for exactly one 16-beat line fill. It then returns the 128-bit line to that cache alone and keeps every other cache stalled through its busywait. It sits between the i-cache bank and the instruction memory, replacing the direct cache-to-memory connection.

## Interface
- NUM_REQ, 4: number of requesting i-caches (2..8)
- ADDR_W, 28: line address width (byte address >> 4)
- LINE_W, 128: line width; fixed at 16 bytes
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- req_read  in  NUM_REQ  per-cache line read request
- req_address  in  NUM_REQ*ADDR_W  per-cache line address; slot i at [i*ADDR_W +: ADDR_W]
- req_readdata  out  LINE_W  line data, broadcast to all caches; valid only for the cache whose busywait is low in DONE
- req_busywait  out  NUM_REQ  per-cache stall
- mem_read  out  1  memory read strobe
- mem_address  out  ADDR_W  memory line address
- mem_readdata  in  LINE_W  memory line data
- mem_busywait  in  1  memory stall; low only in the last beat of a fill
- grant_id  out  $clog2(NUM_REQ)  current/last granted cache
- sync_err  out  1  sticky; beat-count mismatch detected

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_read=0.
  - If any req_read is high, pick a winner, latch its index into grant_id and its address into the addr register, then go to BUSY.
- BUSY:
  - mem_read=1 and mem_address=latched address; both are held constant for the whole fill.
  - beat counter (4 bits) increments every cycle.
  - If mem_busywait is sampled low at a clock edge, go to DONE.
- DONE:
  - mem_read=0 and req_readdata=mem_readdata.
  - req_busywait[grant_id]=0 when req_read[grant_id] is high.
  - Return to IDLE after one cycle.
- req_busywait[i] = req_read[i] && !(state==DONE && grant_id==i). It is combinational.
- Requester withdraws req_read during BUSY:
  - The fill still completes all 16 beats, because the memory's beat counter only resets on reset.
  - DONE is entered and no busywait is lowered; the data is discarded.
- A request arriving during BUSY or DONE waits; it is arbitrated in the next IDLE.
- Winner selection with ICACHE_ARB_RR_EN defined: round-robin (see Configuration).
- Winner selection without ICACHE_ARB_RR_EN: fixed priority, lowest index wins.
- sync_err is set if mem_busywait falls when beat != 15, or if beat wraps 15->0 while mem_busywait is still high. It clears only on reset.

## Timing
- Reset values: state=IDLE, mem_read=0, mem_address=0, grant_id=0, beat=0, sync_err=0, RR pointer=0, req_readdata follows mem_readdata.
- req_busywait resets to 0 whenever req_read is low.
- Reset mid-fill aborts to IDLE immediately. The memory shares the reset, so both beat counters restart at 0 together.
- Latency for an uncontended request:
  - req_read rises in cycle 0; BUSY starts in cycle 1.
  - mem_busywait is low in cycle 16, the 16th BUSY cycle.
  - DONE is in cycle 17, where req_busywait is low and the line is valid.
  - Back-to-back fills are therefore 18 cycles apart.
- The requester must drop req_read, or change its address, at the edge ending DONE. A request still high in IDLE is treated as a new fill.
- Simultaneous requests: exactly one grant per IDLE cycle; the losers stay stalled with no lost requests.

## Configuration
- ICACHE_ARB_RR_EN defined: round-robin. The search starts at (last grant_id+1) mod NUM_REQ, and the pointer updates on each grant.
- ICACHE_ARB_RR_EN not defined: fixed priority with index 0 highest. No pointer register is built.

## Structure
- Shared package icache_arb_pkg holds:
  - the state enum {IDLE, BUSY, DONE};
  - LINE_BEATS=16;
  - LINE_BYTES=16.
- One sub-module, icache_arb_pick: combinational winner select from the request vector and the RR pointer. The pointer input is ignored when round-robin is off.

## Test plan
- Single request, cache 1, address 0x0000000:
  - busywait is high for cycles 0-16 and low in cycle 17;
  - req_readdata[31:0]=0x3e800013, [63:32]=0x00208093;
  - mem_read is high for exactly 16 cycles.
- Caches 0 and 2 request in the same cycle:
  - without RR, cache 0 is served first;
  - cache 2's busywait stays high until its own DONE, in cycle 35.
- RR enabled, all 4 caches request continuously: the grant order is 0,1,2,3,0 with 18 cycles per grant.
- Cache 3 drops req_read in BUSY cycle 5:
  - the fill still runs all 16 beats;
  - no busywait is lowered;
  - the next fill is still aligned, with sync_err=0.
- Reset asserted in BUSY cycle 8, released, then a new request:
  - state returns to IDLE and mem_read=0;
  - the new fill returns the correct line with sync_err=0.
- Memory model forced to drop busywait at beat 10: sync_err=1 and remains set until reset.
